nios2_sysid_ext: RTL and testbench
==================================

# nios2_sysid_ext

Parametrised Avalon-MM system-identification slave for Nios II systems. It extends the two-word ID/timestamp slave to a multi-word register file with:
- registered reads;
- a capability word;
- a prescaled free-running uptime counter with atomic 64-bit snapshot and a sticky overflow flag;
- software scratch registers.

It sits on the system interconnect as a fixed-latency (1 cycle) control slave.

## Interface
- SYSTEM_ID, 32'h0000_1234, value of ID register
- TIMESTAMP, 32'd0, generation timestamp (seconds since epoch)
- VERSION, 16'd2, block version reported in CAPS
- ADDR_W, 4, word-address width; 6+NUM_SCRATCH ≤ 2**ADDR_W
- NUM_SCRATCH, 4, scratch registers (0..16)
- CNT_W, 48, uptime counter width (33..64)
- PRESCALE, 1, clocks per uptime tick (≥1)

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- address  in  ADDR_W  word address
- read  in  1  read strobe
- write  in  1  write strobe
- writedata  in  32  write data
- byteenable  in  4  byte lanes for writes
- readdata  out  32  read data, valid with readdatavalid
- readdatavalid  out  1  one-cycle pulse, one cycle after read

## Operation
Register map (word offsets):
- 0 ID: RO, SYSTEM_ID.
- 1 TS: RO, TIMESTAMP.
- 2 CAPS: RO, {NUM_SCRATCH[7:0], CNT_W[7:0], VERSION}.
- 3 UPTIME_LO: RO, counter[31:0]. The same read captures counter[CNT_W-1:32] into the HI shadow.
- 4 UPTIME_HI: RO, shadow, zero-extended to 32 bits. Not updated by reads of offset 4.
- 5 CONTROL: RW.
  - bit0 RUN: reset 1.
  - bit1 CLEAR: write-1 pulse, reads 0.
  - bit2 OVF: sticky, write-1-to-clear.
  - other bits read 0.
- 6..5+NUM_SCRATCH SCRATCH: RW, byteenable honoured, reset 0.
- Unmapped offsets read 32'h0; writes to them and to RO offsets are ignored.

Uptime counter:
- Prescaler counts 0..PRESCALE-1 while RUN=1 and emits a tick on the terminal count.
- A tick increments the counter.
- At all-ones, the counter wraps to 0 and sets OVF.
- When RUN=0, both prescaler and counter hold.
- CLEAR zeroes the prescaler and counter the cycle after the write, and takes priority over a same-cycle tick.
- CLEAR does not affect OVF.
- If a same-cycle write sets OVF and clears it with 1, the set from the wrap wins (OVF=1).

Access rules:
- read and write in the same cycle: the write executes; the read returns pre-write contents.
- CONTROL byteenable[0]=0: the write to CONTROL is ignored entirely.

## Timing
- Reset values:
  - readdata=0, readdatavalid=0
  - counter, prescaler, shadow = 0
  - RUN=1, OVF=0
  - scratch = 0
- Read latency is exactly 1 cycle; readdatavalid=read delayed one cycle.
- readdata holds its last value when readdatavalid=0.
- A read of UPTIME_LO at cycle N returns the counter value sampled at the rising edge ending cycle N. The shadow updates on the same edge.
- Writes take effect on the edge ending the write cycle. A read of the same register in the next cycle returns the new value.
- No waitrequest; back-to-back reads are supported every cycle.
- Asserting reset_n low mid-transaction aborts it: readdatavalid drops asynchronously and all state returns to reset values.

## Structure
- Package nios2_sysid_ext_pkg holds:
  - register offset localparams (OFF_ID..OFF_SCRATCH0);
  - CONTROL bit indices (RUN, CLEAR, OVF);
  - CAPS field positions;
  - unmapped read value.
- Sub-module sysid_uptime_counter (params CNT_W, PRESCALE) owns:
  - ports: run, clear, count, wrap_pulse;
  - the prescaler and counter.
- Top level owns decode, the HI shadow, CONTROL/OVF, scratch and the read mux/register.

## Test plan
- Reset, then read offsets 0,1,2 → 32'h1234, 0, {8'd4,8'd48,16'd2}; readdatavalid asserted exactly one cycle after each read.
- PRESCALE=4: release reset, wait 40 clocks, read LO then HI → LO=10±1 and HI=0; further reads of HI return the same value while LO advances.
- CNT_W=33, force counter to 33'h1_FFFF_FFFF → next tick gives LO=0, HI=0, CONTROL.OVF=1; write CONTROL=32'h4 → OVF reads 0.
- Write SCRATCH0=32'hA5A5_A5A5, then write 32'h0000_00FF with byteenable=4'b0001 → read returns 32'hA5A5_A5FF; unmapped offset 15 reads 0.
- Write CONTROL RUN=0 → counter frozen across 100 clocks; write CONTROL=32'h3 (RUN+CLEAR) → LO reads 0 next cycle, then resumes counting.
- Assert reset_n mid-read (read at N, reset low before edge N+1) → readdatavalid never pulses; scratch and OVF return to 0.

Source files
------------

// File: rtl/nios2_sysid_ext_pkg.sv
// Shared definitions for the nios2_sysid_ext system-identification slave:
// register map offsets, CONTROL bit positions, CAPS field layout and the
// value returned for unmapped offsets.
package nios2_sysid_ext_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = DATA_W / 8;

    // Word offsets of the register file
    localparam int unsigned OFF_ID        = 0;
    localparam int unsigned OFF_TS        = 1;
    localparam int unsigned OFF_CAPS      = 2;
    localparam int unsigned OFF_UPTIME_LO = 3;
    localparam int unsigned OFF_UPTIME_HI = 4;
    localparam int unsigned OFF_CONTROL   = 5;
    localparam int unsigned OFF_SCRATCH0  = 6;

    // CONTROL register bit indices
    localparam int unsigned CTRL_RUN   = 0;
    localparam int unsigned CTRL_CLEAR = 1;
    localparam int unsigned CTRL_OVF   = 2;

    // CAPS field LSB positions
    localparam int unsigned CAPS_VER_LSB  = 0;
    localparam int unsigned CAPS_CNTW_LSB = 16;
    localparam int unsigned CAPS_NSCR_LSB = 24;

    localparam logic [DATA_W-1:0] UNMAPPED_RDATA = 32'h0;

    // Assemble the capability word {NUM_SCRATCH[7:0], CNT_W[7:0], VERSION}
    function automatic logic [DATA_W-1:0] caps_word(
        input int unsigned nscr,
        input int unsigned cntw,
        input logic [15:0] ver
    );
        logic [DATA_W-1:0] w;
        w = '0;
        w[CAPS_NSCR_LSB +: 8] = 8'(nscr);
        w[CAPS_CNTW_LSB +: 8] = 8'(cntw);
        w[CAPS_VER_LSB +: 16] = ver;
        return w;
    endfunction

endpackage

// File: rtl/nios2_sysid_ext_if.sv
// Avalon-MM slave bus bundle for nios2_sysid_ext.
//   address/read/write/writedata/byteenable : master -> slave
//   readdata/readdatavalid                  : slave -> master
interface nios2_sysid_ext_if #(
    parameter int unsigned ADDR_W = 4
) ();
    import nios2_sysid_ext_pkg::*;

    logic [ADDR_W-1:0] address;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] writedata;
    logic [BE_W-1:0]   byteenable;
    logic [DATA_W-1:0] readdata;
    logic              readdatavalid;

    modport master (
        output address, read, write, writedata, byteenable,
        input  readdata, readdatavalid
    );

    modport slave (
        input  address, read, write, writedata, byteenable,
        output readdata, readdatavalid
    );

endinterface

// File: rtl/nios2_sysid_ext_uptime.sv
// Prescaled free-running uptime counter.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_run          : prescaler and counter advance only while high
//   i_clear        : zero prescaler and counter (wins over a tick)
//   o_count        : current counter value (registered)
//   o_wrap_c       : high in the cycle whose tick wraps all-ones to zero
module sysid_uptime_counter #(
    parameter int unsigned CNT_W    = 48,
    parameter int unsigned PRESCALE = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_run,
    input  logic             i_clear,
    output logic [CNT_W-1:0] o_count,
    output logic             o_wrap_c
);

    localparam int unsigned     PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0]  r_ps;
    logic [CNT_W-1:0] r_count;
    logic             w_tick;

    // Terminal count of the prescaler produces one tick
    assign w_tick   = i_run && (r_ps == PS_LAST);
    assign o_wrap_c = w_tick && (&r_count) && !i_clear;
    assign o_count  = r_count;

    // Registers are only assigned when something changes, so they hold
    // naturally while stopped.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ps    <= '0;
            r_count <= '0;
        end else if (i_clear) begin
            r_ps    <= '0;
            r_count <= '0;
        end else if (i_run) begin
            if (w_tick) begin
                r_ps    <= '0;
                r_count <= r_count + CNT_W'(1);
            end else begin
                r_ps    <= r_ps + PS_W'(1);
            end
        end
    end

endmodule

// File: rtl/nios2_sysid_ext.sv
// Avalon-MM system-identification slave with registered 1-cycle reads.
//   clock, reset_n : system clock, asynchronous active-low reset
//   bus (slave)    : address/read/write/writedata/byteenable in,
//                    readdata/readdatavalid out
// Register file: ID, TS, CAPS, UPTIME_LO/HI (atomic snapshot through a HI
// shadow), CONTROL (RUN, CLEAR pulse, sticky OVF) and scratch words.
module nios2_sysid_ext
    import nios2_sysid_ext_pkg::*;
#(
    parameter logic [31:0] SYSTEM_ID   = 32'h0000_1234,
    parameter logic [31:0] TIMESTAMP   = 32'd0,
    parameter logic [15:0] VERSION     = 16'd2,
    parameter int unsigned ADDR_W      = 4,
    parameter int unsigned NUM_SCRATCH = 4,
    parameter int unsigned CNT_W       = 48,
    parameter int unsigned PRESCALE    = 1
) (
    input  logic                clock,
    input  logic                reset_n,
    nios2_sysid_ext_if.slave    bus
);

    localparam int unsigned HI_W  = CNT_W - 32;
    localparam int unsigned SCR_N = (NUM_SCRATCH == 0) ? 1 : NUM_SCRATCH;

    logic [ADDR_W-1:0] w_addr;
    int unsigned       w_addr_idx;
    logic              w_wr_ctrl;
    logic              w_clear;
    logic              w_wrap;
    logic [CNT_W-1:0]  w_count;
    logic [DATA_W-1:0] w_ctrl_rd;
    logic [DATA_W-1:0] w_rdata_c;

    logic [DATA_W-1:0] r_rdata;
    logic              r_rdv;
    logic [HI_W-1:0]   r_shadow;
    logic              r_run;
    logic              r_ovf;
    logic [DATA_W-1:0] r_scratch [SCR_N];

    assign w_addr     = bus.address;
    assign w_addr_idx = 32'(w_addr);

    // CONTROL writes without lane 0 are dropped completely
    assign w_wr_ctrl = bus.write && (w_addr_idx == OFF_CONTROL) && bus.byteenable[0];
    assign w_clear   = w_wr_ctrl && bus.writedata[CTRL_CLEAR];

    sysid_uptime_counter #(
        .CNT_W    (CNT_W),
        .PRESCALE (PRESCALE)
    ) u_uptime (
        .i_clk    (clock),
        .i_rst_n  (reset_n),
        .i_run    (r_run),
        .i_clear  (w_clear),
        .o_count  (w_count),
        .o_wrap_c (w_wrap)
    );

    // CONTROL read view: CLEAR always reads back as 0
    always_comb begin
        w_ctrl_rd           = '0;
        w_ctrl_rd[CTRL_RUN] = r_run;
        w_ctrl_rd[CTRL_OVF] = r_ovf;
    end

    // Read mux over current (pre-write) register contents
    always_comb begin
        w_rdata_c = UNMAPPED_RDATA;
        if (w_addr_idx == OFF_ID)             w_rdata_c = SYSTEM_ID;
        else if (w_addr_idx == OFF_TS)        w_rdata_c = TIMESTAMP;
        else if (w_addr_idx == OFF_CAPS)      w_rdata_c = caps_word(NUM_SCRATCH, CNT_W, VERSION);
        else if (w_addr_idx == OFF_UPTIME_LO) w_rdata_c = w_count[31:0];
        else if (w_addr_idx == OFF_UPTIME_HI) w_rdata_c = 32'(r_shadow);
        else if (w_addr_idx == OFF_CONTROL)   w_rdata_c = w_ctrl_rd;
        for (int unsigned i = 0; i < NUM_SCRATCH; i++) begin
            if (w_addr_idx == OFF_SCRATCH0 + i) w_rdata_c = r_scratch[i];
        end
    end

    // Read response register; readdata holds between reads
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rdata <= '0;
            r_rdv   <= 1'b0;
        end else begin
            r_rdv <= bus.read;
            if (bus.read) r_rdata <= w_rdata_c;
        end
    end

    // HI shadow is captured by the LO read so LO/HI form one snapshot
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_shadow <= '0;
        end else if (bus.read && (w_addr_idx == OFF_UPTIME_LO)) begin
            r_shadow <= w_count[CNT_W-1:32];
        end
    end

    // CONTROL: RUN is plain RW; OVF is sticky W1C with the wrap winning
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_run <= 1'b1;
            r_ovf <= 1'b0;
        end else begin
            if (w_wr_ctrl) r_run <= bus.writedata[CTRL_RUN];
            if (w_wrap) begin
                r_ovf <= 1'b1;
            end else if (w_wr_ctrl && bus.writedata[CTRL_OVF]) begin
                r_ovf <= 1'b0;
            end
        end
    end

    // Scratch words with per-byte write enables
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < SCR_N; i++) r_scratch[i] <= '0;
        end else if (bus.write) begin
            for (int unsigned i = 0; i < NUM_SCRATCH; i++) begin
                if (w_addr_idx == OFF_SCRATCH0 + i) begin
                    for (int unsigned b = 0; b < BE_W; b++) begin
                        if (bus.byteenable[b]) r_scratch[i][8*b +: 8] <= bus.writedata[8*b +: 8];
                    end
                end
            end
        end
    end

    assign bus.readdata      = r_rdata;
    assign bus.readdatavalid = r_rdv;

endmodule

// File: tb/tb_nios2_sysid_ext.sv
// Directed self-checking bench for nios2_sysid_ext.
// Instance A: defaults with PRESCALE=4. Instance B: CNT_W=33, PRESCALE=1.
module tb_nios2_sysid_ext;

    logic clock = 1'b0;
    logic reset_n;
    int   errors = 0;
    int   checks = 0;

    always #5 clock = ~clock;

    nios2_sysid_ext_if #(.ADDR_W(4)) if_a ();
    nios2_sysid_ext_if #(.ADDR_W(4)) if_b ();

    nios2_sysid_ext #(.PRESCALE(4)) u_dut_a (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (if_a)
    );

    nios2_sysid_ext #(.CNT_W(33), .PRESCALE(1)) u_dut_b (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (if_b)
    );

    task automatic drive(input bit sb, input logic rd, input logic wr, input logic [3:0] a,
                         input logic [31:0] wd, input logic [3:0] be);
        if (sb) begin
            if_b.read = rd; if_b.write = wr; if_b.address = a;
            if_b.writedata = wd; if_b.byteenable = be;
        end else begin
            if_a.read = rd; if_a.write = wr; if_a.address = a;
            if_a.writedata = wd; if_a.byteenable = be;
        end
    endtask

    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cycle();
    endtask

    task automatic sample(input bit sb, output logic [31:0] d, output logic v);
        d = sb ? if_b.readdata : if_a.readdata;
        v = sb ? if_b.readdatavalid : if_a.readdatavalid;
    endtask

    task automatic bus_rd(input bit sb, input logic [3:0] a, output logic [31:0] d, output logic v);
        drive(sb, 1'b1, 1'b0, a, 32'h0, 4'h0);
        cycle();
        drive(sb, 1'b0, 1'b0, 4'h0, 32'h0, 4'h0);
        sample(sb, d, v);
    endtask

    task automatic bus_wr(input bit sb, input logic [3:0] a, input logic [31:0] wd, input logic [3:0] be);
        drive(sb, 1'b0, 1'b1, a, wd, be);
        cycle();
        drive(sb, 1'b0, 1'b0, 4'h0, 32'h0, 4'h0);
    endtask

    task automatic bus_rw(input bit sb, input logic [3:0] a, input logic [31:0] wd, input logic [3:0] be,
                          output logic [31:0] d, output logic v);
        drive(sb, 1'b1, 1'b1, a, wd, be);
        cycle();
        drive(sb, 1'b0, 1'b0, 4'h0, 32'h0, 4'h0);
        sample(sb, d, v);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 4'h0);
        drive(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 4'h0);
        idle(2);
        reset_n = 1'b1;
    endtask

    // Stop B, then load its counter with all-ones so the next tick wraps
    task automatic preload_b_all_ones();
        bus_wr(1'b1, 4'd5, 32'h0, 4'hF);
        force u_dut_b.u_uptime.r_count = 33'h1_FFFF_FFFF;
        #1;
        release u_dut_b.u_uptime.r_count;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 4'h0);
        drive(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 4'h0);
        #12;
        checks++;
        if (if_a.readdatavalid !== 1'b0 || if_a.readdata !== 32'h0) begin
            errors++; $display("FAIL reset_a: rdv=%b rdata=%h want rdv=0 rdata=0", if_a.readdatavalid, if_a.readdata);
        end
        checks++;
        if (if_b.readdatavalid !== 1'b0 || if_b.readdata !== 32'h0) begin
            errors++; $display("FAIL reset_b: rdv=%b rdata=%h want rdv=0 rdata=0", if_b.readdatavalid, if_b.readdata);
        end
        do_reset();
    endtask

    task automatic test_id_regs();
        logic [31:0] d;
        logic        v;
        logic [3:0]  addrs [3] = '{4'd0, 4'd1, 4'd2};
        logic [31:0] exps  [3] = '{32'h0000_1234, 32'h0, 32'h0430_0002};
        for (int i = 0; i < 3; i++) begin
            bus_rd(1'b0, addrs[i], d, v);
            checks++;
            if (d !== exps[i] || v !== 1'b1) begin
                errors++; $display("FAIL id_reg%0d: got %h rdv=%b want %h rdv=1", i, d, v, exps[i]);
            end
            idle(1);
            checks++;
            if (if_a.readdatavalid !== 1'b0) begin
                errors++; $display("FAIL rdv_pulse%0d: rdv=%b want 0", i, if_a.readdatavalid);
            end
        end
        bus_rd(1'b1, 4'd2, d, v);
        checks++;
        if (d !== 32'h0421_0002) begin
            errors++; $display("FAIL caps_b: got %h want %h", d, 32'h0421_0002);
        end
    endtask

    task automatic test_uptime_prescale();
        logic [31:0] lo1, lo2, hi;
        logic        v;
        do_reset();
        idle(40);
        bus_rd(1'b0, 4'd3, lo1, v);
        checks++;
        if (lo1 < 32'd9 || lo1 > 32'd11) begin
            errors++; $display("FAIL uptime_lo: got %0d want 10+-1", lo1);
        end
        bus_rd(1'b0, 4'd4, hi, v);
        checks++;
        if (hi !== 32'h0) begin
            errors++; $display("FAIL uptime_hi: got %h want 0", hi);
        end
        idle(8);
        bus_rd(1'b0, 4'd4, hi, v);
        checks++;
        if (hi !== 32'h0) begin
            errors++; $display("FAIL uptime_hi_again: got %h want 0", hi);
        end
        bus_rd(1'b0, 4'd3, lo2, v);
        checks++;
        if (lo2 !== 32'd12) begin
            errors++; $display("FAIL uptime_lo_advance: got %0d want 12", lo2);
        end
    endtask

    task automatic test_scratch();
        logic [31:0] d;
        logic        v;
        bus_wr(1'b0, 4'd6, 32'hA5A5_A5A5, 4'hF);
        bus_wr(1'b0, 4'd6, 32'h0000_00FF, 4'b0001);
        bus_rd(1'b0, 4'd6, d, v);
        checks++;
        if (d !== 32'hA5A5_A5FF) begin
            errors++; $display("FAIL scratch_be: got %h want %h", d, 32'hA5A5_A5FF);
        end
        bus_wr(1'b0, 4'd15, 32'hFFFF_FFFF, 4'hF);
        bus_rd(1'b0, 4'd15, d, v);
        checks++;
        if (d !== 32'h0) begin
            errors++; $display("FAIL unmapped: got %h want 0", d);
        end
        bus_wr(1'b0, 4'd0, 32'hDEAD_0000, 4'hF);
        bus_rd(1'b0, 4'd0, d, v);
        checks++;
        if (d !== 32'h0000_1234) begin
            errors++; $display("FAIL ro_write: got %h want %h", d, 32'h0000_1234);
        end
    endtask

    task automatic test_run_clear();
        logic [31:0] v1, v2, d;
        logic        v;
        bus_wr(1'b0, 4'd5, 32'h0, 4'hF);
        bus_rd(1'b0, 4'd3, v1, v);
        idle(100);
        bus_rd(1'b0, 4'd3, v2, v);
        checks++;
        if (v2 !== v1) begin
            errors++; $display("FAIL frozen: got %0d want %0d", v2, v1);
        end
        bus_wr(1'b0, 4'd5, 32'h3, 4'hF);
        bus_rd(1'b0, 4'd3, d, v);
        checks++;
        if (d !== 32'h0) begin
            errors++; $display("FAIL clear_lo: got %0d want 0", d);
        end
        idle(20);
        bus_rd(1'b0, 4'd3, d, v);
        checks++;
        if (d !== 32'd5) begin
            errors++; $display("FAIL resume_lo: got %0d want 5", d);
        end
        bus_rd(1'b0, 4'd5, d, v);
        checks++;
        if (d !== 32'h1) begin
            errors++; $display("FAIL ctrl_after_clear: got %h want 1", d);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  addrs [4] = '{4'd0, 4'd1, 4'd2, 4'd6};
        logic [31:0] exps  [4] = '{32'h0000_1234, 32'h0, 32'h0430_0002, 32'hA5A5_A5FF};
        logic [31:0] d;
        logic        v;
        for (int i = 0; i < 4; i++) begin
            bus_rd(1'b0, addrs[i], d, v);
            checks++;
            if (d !== exps[i] || v !== 1'b1) begin
                errors++; $display("FAIL b2b%0d: got %h rdv=%b want %h rdv=1", i, d, v, exps[i]);
            end
        end
        bus_wr(1'b0, 4'd7, 32'h0000_1111, 4'hF);
        bus_rw(1'b0, 4'd7, 32'h0000_2222, 4'hF, d, v);
        checks++;
        if (d !== 32'h0000_1111) begin
            errors++; $display("FAIL rw_old: got %h want %h", d, 32'h0000_1111);
        end
        bus_rd(1'b0, 4'd7, d, v);
        checks++;
        if (d !== 32'h0000_2222) begin
            errors++; $display("FAIL rw_new: got %h want %h", d, 32'h0000_2222);
        end
        bus_wr(1'b0, 4'd5, 32'h0, 4'b1110);
        bus_rd(1'b0, 4'd5, d, v);
        checks++;
        if (d !== 32'h1) begin
            errors++; $display("FAIL ctrl_be0: got %h want 1", d);
        end
    endtask

    task automatic test_ovf();
        logic [31:0] d;
        logic        v;
        preload_b_all_ones();
        bus_rd(1'b1, 4'd3, d, v);
        checks++;
        if (d !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL preload_lo: got %h want ffffffff", d);
        end
        bus_rd(1'b1, 4'd4, d, v);
        checks++;
        if (d !== 32'h1) begin
            errors++; $display("FAIL preload_hi: got %h want 1", d);
        end
        bus_wr(1'b1, 4'd5, 32'h1, 4'hF);
        idle(1);
        bus_rd(1'b1, 4'd3, d, v);
        checks++;
        if (d !== 32'h0) begin
            errors++; $display("FAIL wrap_lo: got %h want 0", d);
        end
        bus_rd(1'b1, 4'd4, d, v);
        checks++;
        if (d !== 32'h0) begin
            errors++; $display("FAIL wrap_hi: got %h want 0", d);
        end
        bus_rd(1'b1, 4'd5, d, v);
        checks++;
        if (d !== 32'h5) begin
            errors++; $display("FAIL ovf_set: got %h want 5", d);
        end
        bus_wr(1'b1, 4'd5, 32'h4, 4'hF);
        bus_rd(1'b1, 4'd5, d, v);
        checks++;
        if (d !== 32'h0) begin
            errors++; $display("FAIL ovf_clear: got %h want 0", d);
        end
    endtask

    task automatic test_reset_mid_read();
        logic [31:0] d;
        logic        v;
        preload_b_all_ones();
        bus_wr(1'b1, 4'd5, 32'h1, 4'hF);
        idle(1);
        bus_wr(1'b1, 4'd6, 32'hDEAD_BEEF, 4'hF);
        bus_rd(1'b1, 4'd5, d, v);
        checks++;
        if (d !== 32'h5) begin
            errors++; $display("FAIL pre_reset_ovf: got %h want 5", d);
        end
        bus_rd(1'b0, 4'd0, d, v);
        drive(1'b1, 1'b1, 1'b0, 4'd5, 32'h0, 4'h0);
        #1 reset_n = 1'b0;
        #1;
        checks++;
        if (if_a.readdatavalid !== 1'b0 || if_b.readdatavalid !== 1'b0) begin
            errors++; $display("FAIL async_drop: rdv_a=%b rdv_b=%b want 0 0", if_a.readdatavalid, if_b.readdatavalid);
        end
        cycle();
        checks++;
        if (if_b.readdatavalid !== 1'b0 || if_b.readdata !== 32'h0) begin
            errors++; $display("FAIL aborted_read: rdv=%b rdata=%h want 0 0", if_b.readdatavalid, if_b.readdata);
        end
        drive(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 4'h0);
        cycle();
        reset_n = 1'b1;
        cycle();
        checks++;
        if (if_b.readdatavalid !== 1'b0) begin
            errors++; $display("FAIL post_reset_rdv: rdv=%b want 0", if_b.readdatavalid);
        end
        bus_rd(1'b1, 4'd6, d, v);
        checks++;
        if (d !== 32'h0) begin
            errors++; $display("FAIL post_reset_scratch: got %h want 0", d);
        end
        bus_rd(1'b1, 4'd5, d, v);
        checks++;
        if (d !== 32'h1) begin
            errors++; $display("FAIL post_reset_ctrl: got %h want 1", d);
        end
    endtask

    initial begin
        test_reset();
        test_id_regs();
        test_uptime_prescale();
        test_scratch();
        test_run_clear();
        test_back_to_back();
        test_ovf();
        test_reset_mid_read();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
